maze_grid_memory: RTL and testbench

Parametrised maze grid store for the binary-maze solver. It holds a ROWS x COLS wall map plus a per-cell visited map, and loads walls row-by-row over a valid/ready stream instead of from a file. It supports mark and unmark of visited cells, so the solver can backtrack. It returns a registered 4-direction free-neighbour vector for the current cell and sits between the maze loader and the solver FSM.

---
 rtl/maze_grid_memory.sv | 185 ++++++++++++++++++
 tb/tb_maze_grid_memory.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_grid_memory.sv
// Maze grid store: per-cell wall and visited bitmaps, row-streamed wall load,
// mark/unmark of visited cells and a registered free-neighbour vector.
module maze_grid_memory #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             init,
  input  logic                             load_valid,
  input  logic [COLS-1:0]                  load_data,
  output logic                             load_ready,
  input  logic [RW-1:0]                    row,
  input  logic [CW-1:0]                    column,
  input  logic                             mark,
  input  logic                             unmark,
  output logic [3:0]                       data_out,
  output logic                             data_valid,
  output logic                             addr_err,
  output logic                             busy,
  output logic [$clog2(ROWS*COLS+1)-1:0]   visited_count
);

  localparam int VCW = $clog2(ROWS*COLS+1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [VCW-1:0]  vcnt_q, vcnt_d;
  logic [COLS-1:0] wall_q [ROWS];
  logic [COLS-1:0] wall_d [ROWS];
  logic [COLS-1:0] vis_q  [ROWS];
  logic [COLS-1:0] vis_d  [ROWS];
  logic [3:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            last_row_s;
  logic            in_range_s;
  logic [RW-1:0]   row_idx_s, up_idx_s, dn_idx_s;
  logic [CW-1:0]   col_idx_s, lf_idx_s, rt_idx_s;
  logic            do_mark_s, do_unmark_s;
  logic [3:0]      nb_s;

  assign last_row_s = (cnt_q == RW'(ROWS-1));
  assign in_range_s = (int'(row) < ROWS) && (int'(column) < COLS);
  // Clamp indices so an out-of-range request never addresses past the arrays.
  assign row_idx_s  = in_range_s ? row : RW'(0);
  assign col_idx_s  = in_range_s ? column : CW'(0);
  assign up_idx_s   = (row_idx_s == RW'(0)) ? row_idx_s : row_idx_s - RW'(1);
  assign dn_idx_s   = (row_idx_s == RW'(ROWS-1)) ? row_idx_s : row_idx_s + RW'(1);
  assign lf_idx_s   = (col_idx_s == CW'(0)) ? col_idx_s : col_idx_s - CW'(1);
  assign rt_idx_s   = (col_idx_s == CW'(COLS-1)) ? col_idx_s : col_idx_s + CW'(1);

  // Mark wins over unmark; both only act on in-range cells in RUN.
  assign do_mark_s   = (state_q == ST_RUN) && in_range_s && mark &&
                       !wall_q[row_idx_s][col_idx_s] && !vis_q[row_idx_s][col_idx_s];
  assign do_unmark_s = (state_q == ST_RUN) && in_range_s && !mark && unmark &&
                       vis_q[row_idx_s][col_idx_s];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: CLEAR sweeps all rows, init enters/restarts LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: state_d = last_row_s ? ST_RUN : ST_CLEAR;
      ST_RUN:   state_d = init ? ST_LOAD : ST_RUN;
      ST_LOAD:  state_d = (!init && load_valid && last_row_s) ? ST_RUN : ST_LOAD;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    load_ready = (state_q == ST_LOAD);
    busy       = (state_q != ST_RUN);
  end

  // Map, row-counter and visited-count updates for every state.
  always_comb begin
    wall_d = wall_q;
    vis_d  = vis_q;
    cnt_d  = cnt_q;
    vcnt_d = vcnt_q;
    case (state_q)
      ST_CLEAR: begin
        wall_d[cnt_q] = '0;
        vis_d[cnt_q]  = '0;
        cnt_d         = last_row_s ? RW'(0) : cnt_q + RW'(1);
      end
      ST_RUN: begin
        if (do_mark_s) begin
          vis_d[row_idx_s][col_idx_s] = 1'b1;
          vcnt_d                      = vcnt_q + VCW'(1);
        end else if (do_unmark_s) begin
          vis_d[row_idx_s][col_idx_s] = 1'b0;
          vcnt_d                      = vcnt_q - VCW'(1);
        end else begin
          vcnt_d = vcnt_q;
        end
        cnt_d = init ? RW'(0) : cnt_q;
      end
      ST_LOAD: begin
        if (init) begin
          cnt_d = RW'(0);
        end else if (load_valid) begin
          wall_d[cnt_q] = load_data;
          vis_d[cnt_q]  = '0;
          if (last_row_s) begin
            cnt_d  = RW'(0);
            vcnt_d = VCW'(0);
          end else begin
            cnt_d  = cnt_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: cnt_d = RW'(0);
    endcase
  end

  // Free-neighbour vector against the post-write visited map (write-first).
  always_comb begin
    nb_s[0] = (row_idx_s != RW'(0)) &&
              !(wall_q[up_idx_s][col_idx_s] | vis_d[up_idx_s][col_idx_s]);
    nb_s[1] = (col_idx_s != CW'(COLS-1)) &&
              !(wall_q[row_idx_s][rt_idx_s] | vis_d[row_idx_s][rt_idx_s]);
    nb_s[2] = (col_idx_s != CW'(0)) &&
              !(wall_q[row_idx_s][lf_idx_s] | vis_d[row_idx_s][lf_idx_s]);
    nb_s[3] = (row_idx_s != RW'(ROWS-1)) &&
              !(wall_q[dn_idx_s][col_idx_s] | vis_d[dn_idx_s][col_idx_s]);
    valid_d = (state_q == ST_RUN);
    err_d   = (state_q == ST_RUN) && !in_range_s;
    if ((state_q == ST_RUN) && in_range_s) begin
      data_d = nb_s;
    end else begin
      data_d = 4'b0000;
    end
  end

  // Control and query-result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= RW'(0);
      vcnt_q  <= VCW'(0);
      data_q  <= 4'b0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      vcnt_q  <= vcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Bitmap storage; CLEAR wipes it after every reset, so no reset term here.
  always_ff @(posedge clock) begin
    wall_q <= wall_d;
    vis_q  <= vis_d;
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign addr_err      = err_q;
  assign visited_count = vcnt_q;

endmodule

// File: tb/tb_maze_grid_memory.sv
// Randomized scoreboard bench for maze_grid_memory on a 10x12 grid.
module tb_maze_grid_memory;

  localparam int ROWS = 10;
  localparam int COLS = 12;
  localparam int RW   = 4;
  localparam int CW   = 4;
  localparam int VCW  = 7;

  logic            clock = 1'b0;
  logic            reset_n = 1'b1;
  logic            init = 1'b0;
  logic            load_valid = 1'b0;
  logic [COLS-1:0] load_data = '0;
  logic            load_ready;
  logic [RW-1:0]   row = '0;
  logic [CW-1:0]   column = '0;
  logic            mark = 1'b0;
  logic            unmark = 1'b0;
  logic [3:0]      data_out;
  logic            data_valid;
  logic            addr_err;
  logic            busy;
  logic [VCW-1:0]  visited_count;

  maze_grid_memory #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock(clock), .reset_n(reset_n), .init(init), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .row(row), .column(column),
    .mark(mark), .unmark(unmark), .data_out(data_out), .data_valid(data_valid),
    .addr_err(addr_err), .busy(busy), .visited_count(visited_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       err;
    logic       busy;
    logic       lready;
    int         vcount;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain arrays and counters following the block's rules.
  bit mw [ROWS][COLS];
  bit mv [ROWS][COLS];
  int mcount;
  int clear_left;
  bit loading;
  int load_row;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit free_cell(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return !mw[r][c] && !mv[r][c];
  endfunction

  task automatic model_step(input bit i_init, input bit lv, input logic [COLS-1:0] ld,
                            input int r, input int c, input bit m, input bit u,
                            output exp_t e);
    e.data = 4'b0000; e.valid = 1'b0; e.err = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
    end else if (loading) begin
      if (i_init) load_row = 0;
      else if (lv) begin
        for (int cc = 0; cc < COLS; cc++) begin
          mw[load_row][cc] = ld[cc];
          mv[load_row][cc] = 1'b0;
        end
        load_row++;
        if (load_row == ROWS) begin loading = 1'b0; mcount = 0; end
      end
    end else begin
      e.valid = 1'b1;
      if (r >= ROWS || c >= COLS) e.err = 1'b1;
      else begin
        if (m) begin
          if (!mw[r][c] && !mv[r][c]) begin mv[r][c] = 1'b1; mcount++; end
        end else if (u && mv[r][c]) begin
          mv[r][c] = 1'b0; mcount--;
        end
        e.data = {free_cell(r+1, c), free_cell(r, c-1), free_cell(r, c+1), free_cell(r-1, c)};
      end
      if (i_init) begin loading = 1'b1; load_row = 0; end
    end
    e.busy   = (clear_left > 0) || loading;
    e.lready = loading;
    e.vcount = mcount;
  endtask

  // Drive one cycle of inputs (called at posedge+2) and queue the expected response.
  task automatic cycle(input bit i_init, input bit lv, input logic [COLS-1:0] ld,
                       input int r, input int c, input bit m, input bit u);
    exp_t e;
    init = i_init; load_valid = lv; load_data = ld;
    row = RW'(r); column = CW'(c); mark = m; unmark = u;
    model_step(i_init, lv, ld, r, c, m, u, e);
    sb.push_back(e);
    @(posedge clock); #2;
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin mw[r][c] = 1'b0; mv[r][c] = 1'b0; end
    mcount = 0; clear_left = ROWS; loading = 1'b0; load_row = 0;
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  function automatic int rcoord(input int lim);
    if ($urandom_range(9) == 0) return $urandom_range(lim + 1, lim);
    return $urandom_range(lim - 1);
  endfunction

  function automatic logic [COLS-1:0] gen_row(input int density);
    logic [COLS-1:0] v;
    for (int c = 0; c < COLS; c++) v[c] = ($urandom_range(99) < density);
    return v;
  endfunction

  task automatic rand_cycle(input int pm, input int pu);
    cycle(1'b0, 1'b0, gen_row(50), rcoord(ROWS), rcoord(COLS),
          $urandom_range(99) < pm, $urandom_range(99) < pu);
  endtask

  task automatic load_rows(input int n, input int density, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max)) cycle(1'b0, 1'b0, gen_row(50), rcoord(ROWS), rcoord(COLS), 1'b1, 1'b1);
      cycle(1'b0, 1'b1, gen_row(density), rcoord(ROWS), rcoord(COLS), 1'b1, 1'b0);
    end
  endtask

  // Monitor: pops one expected record per edge and compares the DUT outputs.
  exp_t mon_e;
  always begin
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("data_valid", 32'(data_valid), 32'(mon_e.valid));
      check("addr_err", 32'(addr_err), 32'(mon_e.err));
      check("busy", 32'(busy), 32'(mon_e.busy));
      check("load_ready", 32'(load_ready), 32'(mon_e.lready));
      check("visited_count", 32'(visited_count), 32'(mon_e.vcount));
      if (mon_e.valid) check("data_out", 32'(data_out), 32'(mon_e.data));
    end
  end

  initial begin
    #2;
    do_reset();
    repeat (14) rand_cycle(0, 0);
    cycle(1'b0, 1'b0, '0, 5, 5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 9, 11, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 10, 0, 1'b1, 1'b0);

    // Random maze with an init restart part-way through the load.
    cycle(1'b1, 1'b0, '0, 1, 1, 1'b0, 1'b0);
    load_rows(3, 25, 2);
    cycle(1'b1, 1'b0, '0, 2, 2, 1'b0, 1'b0);
    load_rows(ROWS, 25, 2);
    repeat (300) rand_cycle(45, 30);

    // Directed maze: only (4,5) is a wall; a 3-cycle load_valid gap mid-load.
    cycle(1'b1, 1'b0, '0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < ROWS; i++) begin
      if (i == 5) repeat (3) cycle(1'b0, 1'b0, 12'hFFF, 0, 0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, (i == 4) ? 12'h020 : 12'h000, 0, 0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, '0, 4, 4, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 3, 3, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 3, 4, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 3, 3, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 4, 5, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 2, 2, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 2, 2, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 2, 3, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 2, 2, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 3, 3, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 3, 3, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 9, 11, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 8, 10, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 10, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 3, 12, 1'b1, 1'b0);

    // Reset part-way through a load, then confirm the whole grid reads open.
    cycle(1'b1, 1'b0, '0, 0, 0, 1'b0, 1'b0);
    load_rows(7, 60, 0);
    do_reset();
    repeat (ROWS) rand_cycle(0, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cycle(1'b0, 1'b0, '0, r, c, 1'b0, 1'b0);
    repeat (100) rand_cycle(50, 30);

    @(posedge clock); #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
